div: RTL

Iterative radix-2 integer divider for the execute stage, companion to the single-cycle multiplier, implementing the RV32M `div`/`divu`/`rem`/`remu` operations. It accepts one operation per start pulse, runs a 32-step restoring shift-subtract loop, and returns the quotient or remainder with a one-cycle `ready` pulse. Division by zero and signed overflow complete early with the architecturally defined results. The pipeline stalls on `div_in.enable` until `div_out.ready`.

---
 rtl/wires.sv | 45 ++++
 rtl/div.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/wires.sv
`default_nettype none
// ============================================================================
//  Module   : wires (package)
//  Purpose  : Shared execute-stage types and constants for the integer divider
//  Revision : 1.0 - initial release
// ============================================================================
package wires;

    // Number of shift-subtract steps for a 32-bit quotient
    localparam int div_steps = 32;

    // One-hot operation select, driven by the decoder beside mul_op
    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } div_op_type;

    typedef struct packed {
        logic [31:0] rdata1;   // dividend
        logic [31:0] rdata2;   // divisor
        div_op_type  div_op;
        logic        enable;   // start pulse
        logic        clear;    // abort
    } div_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic        ready;
    } div_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_type;

    // Two's-complement negate
    function automatic logic [31:0] negate32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module   : div
//  Purpose  : Iterative radix-2 restoring divider for RV32M div/divu/rem/remu
//  Revision : 1.0 - initial release
// ============================================================================
module div
    import wires::*;
(
    input  logic        clock,
    input  logic        reset,
    input  div_in_type  div_in,
    output div_out_type div_out
);

    div_state_type state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic [32:0]   rem_q,   rem_d;
    logic [31:0]   quo_q,   quo_d;
    logic [31:0]   dvs_q,   dvs_d;
    logic          quo_neg_q, quo_neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic          rem_sel_q, rem_sel_d;
    logic [31:0]   result_q, result_d;
    logic          ready_q,  ready_d;

    logic          w_signed;
    logic          w_op_valid;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic [33:0]   w_trial;
    logic [31:0]   w_quo_fix;
    logic [31:0]   w_rem_fix;

    // Next-state logic: capture, shift-subtract iteration and sign-corrected completion
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        w_signed   = div_in.div_op.div | div_in.div_op.rem;
        w_op_valid = |div_in.div_op;
        w_abs_a    = (w_signed && div_in.rdata1[31]) ? negate32(div_in.rdata1) : div_in.rdata1;
        w_abs_b    = (w_signed && div_in.rdata2[31]) ? negate32(div_in.rdata2) : div_in.rdata2;

        // Shifted {rem, quo} partial remainder minus divisor; bit 33 is the borrow
        w_trial    = {rem_q, quo_q[31]} - {2'b00, dvs_q};

        w_quo_fix  = quo_neg_q ? negate32(quo_q)       : quo_q;
        w_rem_fix  = rem_neg_q ? negate32(rem_q[31:0]) : rem_q[31:0];

        case (state_q)
            IDLE: begin
                if (!div_in.clear && div_in.enable && w_op_valid) begin
                    rem_sel_d = div_in.div_op.rem | div_in.div_op.remu;
                    if (div_in.rdata2 == 32'd0) begin
                        // Divide by zero: all-ones quotient, raw dividend as remainder
                        quo_d     = 32'hFFFF_FFFF;
                        rem_d     = {1'b0, div_in.rdata1};
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = DONE;
                    end else if (w_signed && div_in.rdata1 == 32'h8000_0000 &&
                                 div_in.rdata2 == 32'hFFFF_FFFF) begin
                        // Signed overflow: quotient wraps to the dividend, remainder zero
                        quo_d     = 32'h8000_0000;
                        rem_d     = 33'd0;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        count_d   = 5'(div_steps - 1);
                        rem_d     = 33'd0;
                        quo_d     = w_abs_a;
                        dvs_d     = w_abs_b;
                        quo_neg_d = w_signed & (div_in.rdata1[31] ^ div_in.rdata2[31]);
                        rem_neg_d = w_signed & div_in.rdata1[31];
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (div_in.clear) begin
                    state_d = IDLE;
                end else begin
                    if (!w_trial[33]) begin
                        rem_d = w_trial[32:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[31:0], quo_q[31]};
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    count_d = count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!div_in.clear) begin
                    result_d = rem_sel_q ? w_rem_fix : w_quo_fix;
                    ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= 32'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign div_out.result = result_q;
    assign div_out.ready  = ready_q;

endmodule
`default_nettype wire
